// File: rtl/sobel_pkg.sv
// Shared constants and the arbiter state type for the Sobel frame-buffer path.
package sobel_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 14;
    localparam int FRAME_W  = 100;
    localparam int FRAME_H  = 100;
    localparam int DEPTH    = FRAME_W * FRAME_H;
    localparam int MAX_WAIT = 3;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_wrptr.sv
// Write address counter for the frame buffer: wraps after DEPTH-1 and pulses
// o_frame_done alongside the grant of the last pixel of each frame.
module arb_wrptr #(
    parameter int ADDR_W = sobel_pkg::ADDR_W,
    parameter int DEPTH  = sobel_pkg::DEPTH
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              i_adv,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_last,
    output logic              o_frame_done
);

    logic [ADDR_W-1:0] r_ptr;
    logic              r_frame_done;
    logic              w_last;

    assign w_last       = (r_ptr == ADDR_W'(DEPTH - 1));
    assign o_ptr        = r_ptr;
    assign o_last       = w_last;
    assign o_frame_done = r_frame_done;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= i_adv && w_last;
            if (i_adv) begin
                r_ptr <= w_last ? '0 : r_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Single-port frame-buffer arbiter: write priority, forced read after MAX_WAIT
// denials, FILL/RUN phases. Define ARB_STATS_EN to add conflict/starvation counters.
module frame_buf_arbiter
    import sobel_pkg::arb_state_t, sobel_pkg::ST_FILL, sobel_pkg::ST_RUN;
#(
    parameter int DATA_W   = sobel_pkg::DATA_W,
    parameter int ADDR_W   = sobel_pkg::ADDR_W,
    parameter int DEPTH    = sobel_pkg::DEPTH,
    parameter int MAX_WAIT = sobel_pkg::MAX_WAIT
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_done,
    output logic              fill_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
`ifdef ARB_STATS_EN
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       starve_cnt,
`endif
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_t        r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic              w_rd_forced, w_rd_grant, w_wr_grant;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic              w_wr_last;

    logic              r_wr_ack, r_rd_ack, r_rd_valid, r_fill_busy;
    logic              r_ram_en, r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    arb_wrptr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_wrptr (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .i_adv        (w_wr_grant),
        .o_ptr        (w_wr_ptr),
        .o_last       (w_wr_last),
        .o_frame_done (frame_done)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant decision, wait counter and next state from the requests sampled this edge.
    always_comb begin
        w_rd_forced = (r_wait == WAIT_W'(MAX_WAIT));
        w_rd_grant  = rd_req && (r_state == ST_RUN) && (!wr_req || w_rd_forced);
        w_wr_grant  = wr_req && !w_rd_grant;

        w_state_nxt = r_state;
        if ((r_state == ST_FILL) && w_wr_grant && w_wr_last) begin
            w_state_nxt = ST_RUN;
        end

        w_wait_nxt = '0;
        if (rd_req && !w_rd_grant) begin
            w_wait_nxt = w_rd_forced ? r_wait : r_wait + 1'b1;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait      <= '0;
            r_wr_ack    <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_fill_busy <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_wait      <= w_wait_nxt;
            r_wr_ack    <= w_wr_grant;
            r_rd_ack    <= w_rd_grant;
            r_rd_valid  <= r_rd_ack;
            // fill_busy reads 0 while in reset and rises on the first clock after it.
            r_fill_busy <= (w_state_nxt == ST_FILL);
            r_ram_en    <= w_wr_grant || w_rd_grant;
            r_ram_we    <= w_wr_grant;
            if (w_wr_grant) begin
                r_ram_addr  <= w_wr_ptr;
                r_ram_wdata <= wr_data;
            end else if (w_rd_grant) begin
                r_ram_addr  <= rd_addr;
            end
        end
    end

    assign wr_ack    = r_wr_ack;
    assign rd_ack    = r_rd_ack;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_valid ? ram_rdata : '0;
    assign fill_busy = r_fill_busy;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

`ifdef ARB_STATS_EN
    logic [15:0] r_conflict_cnt, r_starve_cnt;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
            r_starve_cnt   <= '0;
        end else begin
            if (wr_req && rd_req && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
            // A read granted while a write is pending can only be a forced one.
            if (w_rd_grant && wr_req && (r_starve_cnt != 16'hFFFF)) begin
                r_starve_cnt <= r_starve_cnt + 16'd1;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign starve_cnt   = r_starve_cnt;
`endif

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Self-checking bench for frame_buf_arbiter with a small-frame override (DEPTH=100).
module tb_frame_buf_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 100;

  logic              sclk;
  logic              rst_n;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_done;
  logic              fill_busy;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
`ifdef ARB_STATS_EN
  logic [15:0]       conflict_cnt;
  logic [15:0]       starve_cnt;
`endif

  frame_buf_arbiter #(
    .DEPTH (DEPTH)
  ) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_done (frame_done),
    .fill_busy  (fill_busy),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
`ifdef ARB_STATS_EN
    .conflict_cnt (conflict_cnt),
    .starve_cnt   (starve_cnt),
`endif
    .ram_rdata  (ram_rdata)
  );

  // clock / reset
  initial begin
    sclk = 1'b0;
    forever #10 sclk = ~sclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // single-port RAM with one-cycle registered read
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge sclk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0]        rd_addr_q[$];
  logic [DATA_W-1:0]        rd_exp_q[$];
  logic [DATA_W-1:0]        exp_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]        ptr_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_write(input logic [DATA_W-1:0] d);
    exp_q.push_back({ptr_m, d});
    exp_mem[ptr_m] = d;
    ptr_m = (ptr_m == ADDR_W'(DEPTH - 1)) ? '0 : ptr_m + 14'd1;
  endtask

  task automatic push_read(input logic [ADDR_W-1:0] a);
    rd_addr_q.push_back(a);
    rd_exp_q.push_back(exp_mem[a]);
  endtask

  // monitor: runs just after each active edge
  logic prev_rd_ack = 1'b0;
  initial begin
    logic [ADDR_W+DATA_W-1:0] e;
    logic [ADDR_W-1:0]        a;
    logic [DATA_W-1:0]        d;
    forever begin
      @(posedge sclk);
      #1;
      if (!rst_n) begin
        prev_rd_ack = 1'b0;
      end else begin
        if (wr_ack || rd_ack) chk("single_grant", 64'(wr_ack && rd_ack), 64'(0));
        if (wr_ack) begin
          if (exp_q.size() == 0) begin
            chk("wr_ack_unexpected", 64'(wr_ack), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("wr_ram_port", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({2'b11, e}));
            chk("frame_done", 64'(frame_done), 64'(e[ADDR_W+DATA_W-1:DATA_W] == ADDR_W'(DEPTH - 1)));
          end
        end else if (frame_done) begin
          chk("frame_done_stray", 64'(frame_done), 64'(0));
        end
        if (rd_ack) begin
          if (rd_addr_q.size() == 0) begin
            chk("rd_ack_unexpected", 64'(rd_ack), 64'(0));
          end else begin
            a = rd_addr_q.pop_front();
            chk("rd_ram_port", 64'({ram_en, ram_we, ram_addr}), 64'({2'b10, a}));
          end
        end
        if (!wr_ack && !rd_ack) chk("idle_ram_en", 64'({ram_en, ram_we}), 64'(0));
        if (rd_valid || prev_rd_ack) begin
          chk("rd_valid_timing", 64'(rd_valid), 64'(prev_rd_ack));
          if (rd_valid && rd_exp_q.size() != 0) begin
            d = rd_exp_q.pop_front();
            chk("rd_data", 64'(rd_data), 64'(d));
          end
        end
        prev_rd_ack = rd_ack;
      end
    end
  end

  // driver: present one pixel and wait (bounded) for its ack
  task automatic write_px(input logic [DATA_W-1:0] d);
    int n;
    wr_req  = 1'b1;
    wr_data = d;
    push_write(d);
    n = 0;
    do begin
      @(negedge sclk);
      n++;
    end while (!wr_ack && n < 50);
    chk("wr_ack_wait", 64'(wr_ack), 64'(1));
  endtask

  typedef struct {
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              exp_wr;
    logic              exp_rd;
  } vec_t;

  function automatic vec_t mk(logic w, logic r, int a, logic ew, logic er);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = ADDR_W'(a); v.exp_wr = ew; v.exp_rd = er;
    return v;
  endfunction

  vec_t tv[14];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    ptr_m   = '0;
    rst_n   = 1'b0;
    wr_req  = 1'b0;
    wr_data = '0;
    rd_req  = 1'b0;
    rd_addr = '0;

    // arbitration table, one row per cycle starting in RUN with an idle wait counter
    tv[0]  = mk(1, 1, 60,  1, 0);
    tv[1]  = mk(1, 1, 60,  1, 0);
    tv[2]  = mk(1, 1, 60,  1, 0);
    tv[3]  = mk(1, 1, 60,  0, 1);
    tv[4]  = mk(1, 1, 61,  1, 0);
    tv[5]  = mk(1, 1, 61,  1, 0);
    tv[6]  = mk(1, 1, 61,  1, 0);
    tv[7]  = mk(1, 1, 61,  0, 1);
    tv[8]  = mk(0, 1, 62,  0, 1);
    tv[9]  = mk(1, 0, 0,   1, 0);
    tv[10] = mk(0, 0, 0,   0, 0);
    tv[11] = mk(1, 1, 63,  1, 0);
    tv[12] = mk(0, 1, 200, 0, 1);
    tv[13] = mk(0, 0, 0,   0, 0);

    // reset state
    repeat (3) @(negedge sclk);
    chk("reset_outputs", 64'({wr_ack, rd_ack, rd_data, rd_valid, frame_done, fill_busy,
                              ram_en, ram_we, ram_addr, ram_wdata}), 64'(0));
    rst_n = 1'b1;
    @(negedge sclk);
    chk("fill_busy_after_reset", 64'(fill_busy), 64'(1));

    // fill a frame while a read waits; reads must stay blocked until RUN
    rd_req  = 1'b1;
    rd_addr = 14'd5;
    for (int i = 0; i < DEPTH; i++) begin
      write_px(8'(i));
      chk("fill_no_rd_ack", 64'(rd_ack), 64'(0));
      chk("fill_busy", 64'(fill_busy), 64'(i < DEPTH - 1));
    end
    wr_req = 1'b0;
    push_read(14'd5);
    @(negedge sclk);
    chk("first_run_rd_ack", 64'(rd_ack), 64'(1));
    rd_req = 1'b0;
    @(negedge sclk);
    chk("first_run_rd_data", 64'({rd_valid, rd_data}), 64'({1'b1, 8'd5}));
    @(negedge sclk);

    // table-driven arbitration in RUN
    for (int i = 0; i < 14; i++) begin
      wr_req  = tv[i].wr;
      rd_req  = tv[i].rd;
      rd_addr = tv[i].addr;
      wr_data = 8'hC0 + 8'(i);
      if (tv[i].exp_wr) push_write(wr_data);
      if (tv[i].exp_rd) push_read(tv[i].addr);
      @(negedge sclk);
      chk($sformatf("tbl_wr_ack[%0d]", i), 64'(wr_ack), 64'(tv[i].exp_wr));
      chk($sformatf("tbl_rd_ack[%0d]", i), 64'(rd_ack), 64'(tv[i].exp_rd));
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (2) @(negedge sclk);

    // write 0xA5 at address 42, then read it back with a two-cycle latency
    while (ptr_m != 14'd42) write_px(8'($urandom_range(0, 255)));
    write_px(8'hA5);
    wr_req = 1'b0;
    @(negedge sclk);
    rd_req  = 1'b1;
    rd_addr = 14'd42;
    push_read(14'd42);
    @(negedge sclk);
    chk("a5_rd_ack", 64'(rd_ack), 64'(1));
    rd_req = 1'b0;
    @(negedge sclk);
    chk("a5_rd_valid", 64'(rd_valid), 64'(1));
    chk("a5_rd_data", 64'(rd_data), 64'(8'hA5));

    // reset mid-frame at pointer 57 with a read result still in flight
    while (ptr_m != 14'd57) write_px(8'($urandom_range(0, 255)));
    wr_req  = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 14'd10;
    push_read(14'd10);
    @(negedge sclk);
    chk("pre_reset_rd_ack", 64'(rd_ack), 64'(1));
    rd_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({wr_ack, rd_ack, rd_data, rd_valid, frame_done, fill_busy,
                                    ram_en, ram_we, ram_addr, ram_wdata}), 64'(0));
    exp_q.delete();
    rd_addr_q.delete();
    rd_exp_q.delete();
    ptr_m = '0;
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
    chk("no_stale_rd_valid", 64'(rd_valid), 64'(0));
    chk("refill_busy", 64'(fill_busy), 64'(1));

    rd_req  = 1'b1;
    rd_addr = 14'd3;
    for (int i = 0; i < 3; i++) begin
      write_px(8'h10 + 8'(i));
      chk("refill_no_rd_ack", 64'(rd_ack), 64'(0));
      chk("refill_busy_hold", 64'(fill_busy), 64'(1));
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (4) @(negedge sclk);
    chk("wr_queue_drained", 64'(exp_q.size()), 64'(0));
    chk("rd_queue_drained", 64'(rd_exp_q.size() + rd_addr_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
